// File: rtl/decex_pkg.sv
// decex_pkg: shared constants and types for the decode/execute slice.
//   - MIPS opcode and funct field encodings
//   - 4-bit ALU operation codes and 2-bit ALUOp class codes
//   - packed control-strobe bundle produced by the main decoder
package decex_pkg;

  localparam int DATA_W = 32;

  // Opcode field ins[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Funct field ins[5:0]
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_NOP = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ALT    = 2'b11
  } aluop_e;

  typedef struct packed {
    logic   reg_dst;
    logic   alu_src;
    logic   mem_to_reg;
    logic   reg_write;
    logic   mem_read;
    logic   mem_write;
    aluop_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/decex_if.sv
// decex_if: operand/instruction bundle into the decode-execute unit and the
// control/result bundle back out.
//   master: drives instruction, funct, reg1, reg2; observes the rest
//   slave : the decode-execute unit itself
interface decex_if;
  import decex_pkg::*;

  logic [5:0]        instruction;
  logic [5:0]        funct;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;

  logic              RegDst;
  logic              ALUSrc;
  logic              MemtoReg;
  logic              RegWrite;
  logic              MemRead;
  logic              MemWrite;
  logic [1:0]        ALUOp;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;

  modport master (
    output instruction, funct, reg1, reg2,
    input  RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
    input  ALUOp, opcode, result, zero, result_q, zero_q
  );

  modport slave (
    input  instruction, funct, reg1, reg2,
    output RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
    output ALUOp, opcode, result, zero, result_q, zero_q
  );
endinterface

// File: rtl/decex_alu.sv
// decex_alu: purely combinational 32-bit ALU core.
//   op_i     : ALU operation code (alu_op_e)
//   a_i, b_i : signed operands
//   result_o : modulo-2^32 result; unlisted codes give 0
//   zero_o   : high when result_o is zero
// Build option DECEX_SLT_EN: when defined, ALU_SLT performs a signed
// set-less-than; otherwise it falls through to a zero result.
module decex_alu
  import decex_pkg::*;
(
  input  alu_op_e                  op_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] result_o,
  output logic                     zero_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_NOR: result_o = ~(a_i | b_i);
`ifdef DECEX_SLT_EN
      ALU_SLT: result_o = (a_i < b_i) ? DATA_W'(1) : '0;
`endif
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/decode_execute_unit.sv
// decode_execute_unit: main control decoder, ALU-control decoder and ALU for
// a single-cycle MIPS datapath, plus a status register holding the last
// result and zero flag.
//   clk   : rising-edge clock
//   reset : synchronous active-high; clears only result_q/zero_q
//   bus   : decex_if.slave (instruction/funct/reg1/reg2 in; control strobes,
//           ALUOp, opcode, result, zero, result_q, zero_q out)
// Build option DECEX_SLT_EN: enables the SLT funct decode and signed SLT in
// the ALU; without it funct 101010 decodes to ALU_NOP.
module decode_execute_unit
  import decex_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  decex_if.slave bus
);

  ctrl_t                    ctrl;
  alu_op_e                  alu_code;
  logic signed [DATA_W-1:0] alu_res;
  logic                     alu_zero;

  logic signed [DATA_W-1:0] result_d, result_q;
  logic                     zero_d, zero_q;

  // Main decoder: unknown opcodes leave every strobe low so nothing is written.
  always_comb begin
    ctrl = '{default: '0, alu_op: ALUOP_MEM};
    case (bus.instruction)
      OP_RTYPE: ctrl = '{reg_dst: 1'b1, alu_src: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b1,
                         mem_read: 1'b0, mem_write: 1'b0, alu_op: ALUOP_RTYPE};
      OP_LW:    ctrl = '{reg_dst: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b1, reg_write: 1'b1,
                         mem_read: 1'b1, mem_write: 1'b0, alu_op: ALUOP_MEM};
      OP_SW:    ctrl = '{reg_dst: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b0, reg_write: 1'b0,
                         mem_read: 1'b0, mem_write: 1'b1, alu_op: ALUOP_MEM};
      OP_BEQ:   ctrl = '{reg_dst: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b0,
                         mem_read: 1'b0, mem_write: 1'b0, alu_op: ALUOP_BRANCH};
      OP_ADDI:  ctrl = '{reg_dst: 1'b0, alu_src: 1'b1, mem_to_reg: 1'b0, reg_write: 1'b1,
                         mem_read: 1'b0, mem_write: 1'b0, alu_op: ALUOP_MEM};
      default:  ctrl = '{default: '0, alu_op: ALUOP_MEM};
    endcase
  end

  // ALU-control decoder: the unsigned add/sub variants share the signed ops
  // because no overflow trap exists.
  always_comb begin
    alu_code = ALU_ADD;
    case (ctrl.alu_op)
      ALUOP_MEM:    alu_code = ALU_ADD;
      ALUOP_BRANCH: alu_code = ALU_SUB;
      ALUOP_ALT:    alu_code = ALU_ADD;
      ALUOP_RTYPE: begin
        case (bus.funct)
          FN_ADD, FN_ADDU: alu_code = ALU_ADD;
          FN_SUB, FN_SUBU: alu_code = ALU_SUB;
          FN_AND:          alu_code = ALU_AND;
          FN_OR:           alu_code = ALU_OR;
          FN_NOR:          alu_code = ALU_NOR;
`ifdef DECEX_SLT_EN
          FN_SLT:          alu_code = ALU_SLT;
`endif
          default:         alu_code = ALU_NOP;
        endcase
      end
      default:      alu_code = ALU_ADD;
    endcase
  end

  decex_alu u_alu (
    .op_i     (alu_code),
    .a_i      (bus.reg1),
    .b_i      (bus.reg2),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  assign result_d = alu_res;
  assign zero_d   = alu_zero;

  // Status register stage: one cycle behind the combinational result.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.RegDst   = ctrl.reg_dst;
  assign bus.ALUSrc   = ctrl.alu_src;
  assign bus.MemtoReg = ctrl.mem_to_reg;
  assign bus.RegWrite = ctrl.reg_write;
  assign bus.MemRead  = ctrl.mem_read;
  assign bus.MemWrite = ctrl.mem_write;
  assign bus.ALUOp    = ctrl.alu_op;
  assign bus.opcode   = alu_code;
  assign bus.result   = alu_res;
  assign bus.zero     = alu_zero;
  assign bus.result_q = result_q;
  assign bus.zero_q   = zero_q;

endmodule

// File: tb/tb_decode_execute_unit.sv
// tb_decode_execute_unit: directed and randomized checks of the decode-execute
// unit against a table-level reference model.
module tb_decode_execute_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decex_if bus ();

  decode_execute_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q;
  logic        exp_zq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: strobe table {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,ALUOp}
  function automatic logic [7:0] m_ctrl(input logic [5:0] ins);
    case (ins)
      6'b000000: return 8'b100100_10;
      6'b100011: return 8'b011110_00;
      6'b101011: return 8'b010001_00;
      6'b000100: return 8'b000000_01;
      6'b001000: return 8'b010100_00;
      default:   return 8'b000000_00;
    endcase
  endfunction

  function automatic logic [3:0] m_code(input logic [1:0] aluop, input logic [5:0] fn);
    if (aluop == 2'b01) return 4'b0110;
    if (aluop != 2'b10) return 4'b0010;
    case (fn)
      6'b100000, 6'b100001: return 4'b0010;
      6'b100010, 6'b100011: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100111: return 4'b1100;
`ifdef DECEX_SLT_EN
      6'b101010: return 4'b0111;
`endif
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_res(input logic [3:0] code, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (code)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      4'b0110: return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // Drive one instruction, check the combinational outputs, then check the
  // status register after the following rising edge.
  task automatic step(input string tag, input logic [5:0] ins, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ec;
    logic [3:0]  eo;
    logic [31:0] er;
    @(negedge clk);
    bus.instruction = ins;
    bus.funct       = fn;
    bus.reg1        = a;
    bus.reg2        = b;
    #1;
    ec = m_ctrl(ins);
    eo = m_code(ec[1:0], fn);
    er = m_res(eo, a, b);
    check({tag, ".ctrl"}, {24'd0, bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.RegWrite,
                           bus.MemRead, bus.MemWrite, bus.ALUOp}, {24'd0, ec});
    check({tag, ".opcode"}, {28'd0, bus.opcode}, {28'd0, eo});
    check({tag, ".result"}, bus.result, er);
    check({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, (er == 32'd0)});
    exp_q  = er;
    exp_zq = (er == 32'd0);
    @(posedge clk);
    #1;
    check({tag, ".result_q"}, bus.result_q, exp_q);
    check({tag, ".zero_q"}, {31'd0, bus.zero_q}, {31'd0, exp_zq});
  endtask

  logic [5:0] ins_pool [6];
  logic [5:0] fn_pool [9];

  initial begin
    ins_pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000000};
    fn_pool  = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                 6'b100101, 6'b100111, 6'b101010, 6'b000000};

    // Reset with a nonzero result present: reset wins, strobes still decode.
    reset           = 1'b1;
    bus.instruction = 6'b100011;
    bus.funct       = 6'b000000;
    bus.reg1        = 32'd5;
    bus.reg2        = 32'd0;
    #1;
    check("rst.memread_live", {31'd0, bus.MemRead}, 32'd1);
    check("rst.result_live", bus.result, 32'd5);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst.result_q", bus.result_q, 32'd0);
    check("rst.zero_q", {31'd0, bus.zero_q}, 32'd0);

    step("addi", 6'b001000, 6'b000000, 32'd0, 32'd1);
    check("addi.abs_result", bus.result_q, 32'd1);
    step("add", 6'b000000, 6'b100000, 32'd1, 32'd1);
    check("add.abs_result", bus.result, 32'd2);
    step("sub", 6'b000000, 6'b100010, 32'd3, 32'd5);
    check("sub.abs_result", bus.result, 32'hFFFF_FFFE);
    step("slt", 6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1);
`ifdef DECEX_SLT_EN
    check("slt.abs_result", bus.result, 32'd1);
`else
    check("slt.abs_opcode", {28'd0, bus.opcode}, 32'hF);
    check("slt.abs_zero", {31'd0, bus.zero}, 32'd1);
`endif
    step("lw", 6'b100011, 6'b000000, 32'd0, 32'd0);
    step("sw", 6'b101011, 6'b000000, 32'd0, 32'd0);
    check("sw.abs_memwrite", {31'd0, bus.MemWrite}, 32'd1);
    step("illegal", 6'b111111, 6'b100000, 32'd7, 32'd9);
    step("and", 6'b000000, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("and.abs_result", bus.result, 32'h00F0_00F0);
    step("or", 6'b000000, 6'b100101, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("or.abs_result", bus.result, 32'hFFF0_FFF0);
    step("nor", 6'b000000, 6'b100111, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("nor.abs_result", bus.result, 32'h000F_000F);
    step("beq_eq", 6'b000100, 6'b000000, 32'h1234_5678, 32'h1234_5678);
    step("addu_wrap", 6'b000000, 6'b100001, 32'hFFFF_FFFF, 32'd2);
    step("subu", 6'b000000, 6'b100011, 32'd10, 32'd3);
    step("badfn", 6'b000000, 6'b000111, 32'd4, 32'd4);
    step("slt_pos", 6'b000000, 6'b101010, 32'd1, 32'h8000_0000);

    for (int i = 0; i < 300; i++) begin
      logic [5:0]  ins, fn;
      logic [31:0] a, b;
      ins = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ins_pool[$urandom_range(0, 5)];
      fn  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 8)];
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      step("rand", ins, fn, a, b);
    end

    // Mid-run reset clears the status register again.
    @(negedge clk);
    bus.instruction = 6'b001000;
    bus.reg1        = 32'd100;
    bus.reg2        = 32'd1;
    reset           = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst2.result_q", bus.result_q, 32'd0);
    check("rst2.zero_q", {31'd0, bus.zero_q}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_execute_unit.md
# decode_execute_unit

Combined main control decoder, ALU-control decoder and 32-bit ALU for the single-cycle MIPS datapath. It takes the instruction opcode and funct fields plus two 32-bit operands and produces the datapath control strobes, the 4-bit ALU operation code and the ALU result. The outputs are combinational so the datapath completes in one cycle. A clocked status register also captures the last result and zero flag.

## Interface
- No parameters. Data width is fixed at 32 bits.
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high; clears the status registers only.
- instruction  input  6  opcode field, ins[31:26].
- funct  input  6  funct field, ins[5:0].
- reg1  input  32  ALU operand A, the register-file read port 1.
- reg2  input  32  ALU operand B, already selected by the external ALUSrc mux.
- RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite  output  1 each  datapath control strobes.
- ALUOp  output  2  main-decoder class code.
- opcode  output  4  ALU operation select.
- result  output  32  combinational ALU result.
- zero  output  1  high when result == 0.
- result_q  output  32  registered result.
- zero_q  output  1  registered zero flag.

## Operation
Main decode, with strobes in the order RegDst/ALUSrc/MemtoReg/RegWrite/MemRead/MemWrite followed by ALUOp:
- 000000 R-type: 1/0/0/1/0/0, ALUOp 10.
- 100011 lw: 0/1/1/1/1/0, ALUOp 00.
- 101011 sw: 0/1/0/0/0/1, ALUOp 00.
- 000100 beq: 0/0/0/0/0/0, ALUOp 01.
- 001000 addi: 0/1/0/1/0/0, ALUOp 00.
- Any other opcode: all strobes 0, ALUOp 00. No write side effects.

ALU control (opcode output):
- ALUOp 00 → 0010 (ADD).
- ALUOp 01 → 0110 (SUB).
- ALUOp 11 → 0010 (ADD).
- ALUOp 10 decodes funct:
  - 100000 → 0010 ADD
  - 100010 → 0110 SUB
  - 100100 → 0000 AND
  - 100101 → 0001 OR
  - 100111 → 1100 NOR
  - 101010 → 0111 SLT (see Configuration)
  - any other funct → 1111
- ADDU (100001) and SUBU (100011) map to ADD and SUB respectively.

ALU:
- Arithmetic is modulo 2^32. No overflow detection or trap.
- SLT compares signed: result is 32'd1 if $signed(reg1) < $signed(reg2), else 0.
- Opcode 1111 and any other unlisted code give result 0.
- zero = (result == 0). It is valid for every opcode, including 1111, where zero = 1.

## Timing
- Decode and ALU paths are purely combinational, with zero latency from instruction/funct/reg1/reg2 to all outputs except result_q and zero_q.
- result_q and zero_q update on the rising clk edge: they take the current result and zero, one cycle of latency.
- When reset is high at a rising edge, result_q = 0 and zero_q = 0. Reset has priority over capture.
- Reset does not force any combinational output. Control strobes follow instruction even while reset is high.
- Before the first reset, result_q and zero_q are undefined.

## Configuration
- DECEX_SLT_EN defined: funct 101010 under ALUOp 10 decodes to 0111, and the ALU implements signed SLT.
- DECEX_SLT_EN undefined: funct 101010 decodes to 1111, and result = 0.
- All other behaviour is identical in both builds.

## Structure
- Shared package decex_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI.
  - funct constants.
  - the 4-bit ALU code constants ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_NOP.
  - the 2-bit ALUOp encodings.
- One natural sub-module is decex_alu, the pure combinational arithmetic core. The two decoders live inline in the top.

## Test plan
- reset=1 for one edge, then 0 → result_q = 0, zero_q = 0. On the next edge, with addi, reg1=0, reg2=1: result = 1, result_q = 1, zero_q = 0.
- instruction 001000, reg1=0, reg2=1 → ALUSrc=1, RegWrite=1, RegDst=0, MemtoReg=0, ALUOp=00, opcode=0010, result=1.
- R-type with funct 100000, reg1=1, reg2=1 → RegDst=1, ALUOp=10, result=2. With funct 100010, reg1=3, reg2=5 → result=32'hFFFFFFFE, zero=0.
- R-type with funct 101010, reg1=32'hFFFFFFFF, reg2=1 → with DECEX_SLT_EN: result=1. Without it: opcode=1111, result=0, zero=1.
- lw (100011) → MemRead=1, MemtoReg=1, RegWrite=1. sw (101011) → MemWrite=1, RegWrite=0. Both with reg1=0, reg2=0 give result=0, zero=1.
- instruction 111111 → all strobes 0, ALUOp=00. Also AND/OR/NOR on 32'hF0F0F0F0 and 32'h0FF00FF0 → 32'h00F000F0, 32'hFFF0FFF0, 32'h000F000F.
